// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//
// Memory-side responder for the 6-bit microcoded CPU. It owns a 2**aW-word
// store, a memory-mapped output register at IOADDR and a handshaked program
// loader that fills the store while the CPU is held off via cpuRun.
//
// Ports:
//   clk        board clock, every register uses it
//   rst        synchronous active-low reset
//   memAddr    CPU address
//   writeData  CPU write data
//   writeEn    CPU write strobe, qualified every clk edge
//   readData   registered read data (1 clk latency, read-first)
//   ioIn       external value returned on reads of IOADDR
//   ioOut      output register written by the CPU at IOADDR
//   ldStart    begins a program load (from IDLE)
//   ldValid    loader word valid
//   ldData     loader word
//   ldLast     final loader word marker, qualified with ldValid
//   ldReady    loader may transfer (high in LOAD)
//   ldDone     one-cycle pulse when a load completes
//   cpuRun     high while the CPU may run
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int              Wwid   = 6,
    parameter int              aW     = 6,
    parameter logic [aW-1:0]   IOADDR = 6'h3F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [aW-1:0]   memAddr,
    input  logic [Wwid-1:0] writeData,
    input  logic            writeEn,
    output logic [Wwid-1:0] readData,
    input  logic [Wwid-1:0] ioIn,
    output logic [Wwid-1:0] ioOut,
    input  logic            ldStart,
    input  logic            ldValid,
    input  logic [Wwid-1:0] ldData,
    input  logic            ldLast,
    output logic            ldReady,
    output logic            ldDone,
    output logic            cpuRun
);

    localparam int            DEPTH   = 2 ** aW;
    localparam logic [aW-1:0] PTR_MAX = '1;
    localparam logic [aW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [aW-1:0]   r_ld_ptr;
    logic [Wwid-1:0] r_read_data;
    logic [Wwid-1:0] r_io_out;

    // Store contents are deliberately left out of reset so the array can map
    // onto block RAM.
    logic [Wwid-1:0] r_mem [DEPTH];

    // Write qualification. rst is folded into every enable so that a reset
    // edge performs no write of any kind.
    logic            w_in_idle;
    logic            w_in_load;
    logic            w_cpu_wr;
    logic            w_cpu_io_hit;
    logic            w_io_wr;
    logic            w_ld_accept;
    logic            w_mem_we;
    logic [aW-1:0]   w_mem_addr;
    logic [Wwid-1:0] w_mem_data;

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_load    = (r_state == ST_LOAD);
    assign w_cpu_io_hit = (memAddr == IOADDR);
    assign w_cpu_wr     = rst && w_in_idle && writeEn;
    assign w_io_wr      = w_cpu_wr && w_cpu_io_hit;
    // ldReady is exactly "in LOAD", so the handshake reduces to ldValid here.
    assign w_ld_accept  = rst && w_in_load && ldValid;

    // The CPU and loader never write in the same state, so one port suffices.
    // The loader may write IOADDR's store slot; the CPU cannot.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = memAddr;
        w_mem_data = writeData;
        if (w_ld_accept) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_ld_ptr;
            w_mem_data = ldData;
        end else if (w_cpu_wr && !w_cpu_io_hit) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read. Non-blocking semantics give read-first behaviour when
    // the same address is written on this edge. IOADDR reads return ioIn,
    // never the ioOut register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_read_data <= '0;
        end else if (w_cpu_io_hit) begin
            r_read_data <= ioIn;
        end else begin
            r_read_data <= r_mem[memAddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_io_out <= '0;
        end else if (w_io_wr) begin
            r_io_out <= writeData;
        end
    end

    // Load pointer: cleared when a load starts, advanced per accepted word,
    // wrapping naturally at aW bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ld_ptr <= '0;
        end else if (w_in_idle && ldStart) begin
            r_ld_ptr <= '0;
        end else if (w_ld_accept) begin
            r_ld_ptr <= r_ld_ptr + PTR_ONE;
        end
    end

    // ---------------- loader FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- loader FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ldStart) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Terminate on the explicit last word or once the word at
                // the top address has been written (store full).
                if (ldValid && (ldLast || (r_ld_ptr == PTR_MAX))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- loader FSM: outputs (state decode only) ----------------
    always_comb begin
        cpuRun  = 1'b1;
        ldReady = 1'b0;
        ldDone  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cpuRun  = 1'b1;
            end
            ST_LOAD: begin
                cpuRun  = 1'b0;
                ldReady = 1'b1;
            end
            ST_DONE: begin
                cpuRun  = 1'b0;
                ldDone  = 1'b1;
            end
            default: begin
                cpuRun  = 1'b1;
            end
        endcase
    end

    assign readData = r_read_data;
    assign ioOut    = r_io_out;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
//
// Self-checking bench. Expected readData values are queued when a read
// address is driven and compared #1 after the next rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

    logic       clk;
    logic       rst;
    logic [5:0] memAddr;
    logic [5:0] writeData;
    logic       writeEn;
    logic [5:0] readData;
    logic [5:0] ioIn;
    logic [5:0] ioOut;
    logic       ldStart;
    logic       ldValid;
    logic [5:0] ldData;
    logic       ldLast;
    logic       ldReady;
    logic       ldDone;
    logic       cpuRun;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    cpu_mem_responder #(
        .Wwid  (6),
        .aW    (6),
        .IOADDR(6'h3F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memAddr  (memAddr),
        .writeData(writeData),
        .writeEn  (writeEn),
        .readData (readData),
        .ioIn     (ioIn),
        .ioOut    (ioOut),
        .ldStart  (ldStart),
        .ldValid  (ldValid),
        .ldData   (ldData),
        .ldLast   (ldLast),
        .ldReady  (ldReady),
        .ldDone   (ldDone),
        .cpuRun   (cpuRun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ldDone high cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (ldDone === 1'b1) done_cnt++;
    end

    // Advance one clock and retire every queued readData expectation.
    task automatic tick();
        logic [5:0] e;
        string      n;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (readData !== e) begin
                errors++;
                $display("FAIL %s: readData=%h expected=%h", n, readData, e);
            end else begin
                $display("rd %s: readData=%h", n, readData);
            end
        end
    endtask

    task automatic expect_rd(input logic [5:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic idle_inputs();
        writeEn = 1'b0;
        ldStart = 1'b0;
        ldValid = 1'b0;
        ldLast  = 1'b0;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [5:0] d);
        memAddr = a; writeData = d; writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
    endtask

    task automatic cpu_read(input logic [5:0] a, input logic [5:0] e, input string n);
        memAddr = a; writeEn = 1'b0;
        expect_rd(e, n);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        memAddr = 6'd5; writeData = 6'h00; ldData = 6'h00; ioIn = 6'h00;
        expect_rd(6'h00, "reset_rd0");
        tick();
        expect_rd(6'h00, "reset_rd1");
        tick();
        checks++;
        if (ioOut !== 6'h00) begin errors++; $display("FAIL reset_ioOut: got %h need 00", ioOut); end
        checks++;
        if ({cpuRun, ldReady, ldDone} !== 3'b100) begin
            errors++; $display("FAIL reset_ctrl: cpuRun/ldReady/ldDone=%b need 100", {cpuRun, ldReady, ldDone});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        cpu_write(6'd5, 6'h2A);
        cpu_read(6'd5, 6'h2A, "wr_rd_addr5");
        cpu_write(6'd6, 6'h31);
        cpu_read(6'd6, 6'h31, "wr_rd_addr6");
        cpu_read(6'd5, 6'h2A, "wr_rd_addr5_again");
    endtask

    task automatic test_read_during_write();
        cpu_write(6'd9, 6'h11);
        memAddr = 6'd9; writeData = 6'h22; writeEn = 1'b1;
        expect_rd(6'h11, "rdw_old_word");
        tick();
        writeEn = 1'b0;
        expect_rd(6'h22, "rdw_new_word");
        tick();
    endtask

    task automatic test_io();
        ioIn = 6'h07;
        memAddr = 6'h3F; writeData = 6'h15; writeEn = 1'b1;
        expect_rd(6'h07, "io_rd_during_wr");
        tick();
        writeEn = 1'b0;
        checks++;
        if (ioOut !== 6'h15) begin errors++; $display("FAIL io_out: got %h need 15", ioOut); end
        cpu_read(6'h3F, 6'h07, "io_rd_ioIn");
        ioIn = 6'h2C;
        cpu_read(6'h3F, 6'h2C, "io_rd_ioIn2");
    endtask

    task automatic test_load();
        int d0;
        cpu_write(6'd3, 6'h30);
        cpu_write(6'd10, 6'h0C);
        d0 = done_cnt;
        // ldStart together with a CPU write: the write is still taken.
        ldStart = 1'b1; memAddr = 6'd20; writeData = 6'h2D; writeEn = 1'b1;
        tick();
        ldStart = 1'b0; writeEn = 1'b0;
        checks++;
        if ({cpuRun, ldReady} !== 2'b01) begin errors++; $display("FAIL load_enter: cpuRun/ldReady=%b need 01", {cpuRun, ldReady}); end
        ldValid = 1'b1; ldData = 6'h01; tick();
        ldValid = 1'b0; tick();
        // CPU write during LOAD must be dropped.
        memAddr = 6'd10; writeData = 6'h3E; writeEn = 1'b1; tick();
        writeEn = 1'b0;
        checks++;
        if (cpuRun !== 1'b0) begin errors++; $display("FAIL load_gap_cpuRun: got %b need 0", cpuRun); end
        ldValid = 1'b1; ldData = 6'h02; tick();
        ldData = 6'h03; ldLast = 1'b1; tick();
        checks++;
        if ({cpuRun, ldReady, ldDone} !== 3'b001) begin
            errors++; $display("FAIL load_done_state: cpuRun/ldReady/ldDone=%b need 001", {cpuRun, ldReady, ldDone});
        end
        // DONE ignores ldValid.
        ldData = 6'h3B; ldLast = 1'b0; tick();
        ldValid = 1'b0;
        checks++;
        if ({cpuRun, ldReady, ldDone} !== 3'b100) begin
            errors++; $display("FAIL load_back_idle: cpuRun/ldReady/ldDone=%b need 100", {cpuRun, ldReady, ldDone});
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL load_done_pulses: got %0d need 1", done_cnt - d0); end
        cpu_read(6'd0, 6'h01, "load_addr0");
        cpu_read(6'd1, 6'h02, "load_addr1");
        cpu_read(6'd2, 6'h03, "load_addr2");
        cpu_read(6'd3, 6'h30, "load_done_ignored");
        cpu_read(6'd10, 6'h0C, "load_cpu_wr_dropped");
        cpu_read(6'd20, 6'h2D, "load_start_wr_taken");
    endtask

    task automatic test_full_load();
        int d0;
        d0 = done_cnt;
        ldStart = 1'b1; tick();
        ldStart = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ldValid = 1'b1; ldData = 6'(i) ^ 6'h2A; ldLast = 1'b0;
            tick();
            if (i == 62) begin
                checks++;
                if (ldDone !== 1'b0) begin errors++; $display("FAIL full_early_done: got %b need 0", ldDone); end
            end
        end
        checks++;
        if (ldDone !== 1'b1) begin errors++; $display("FAIL full_done_after_63: got %b need 1", ldDone); end
        // Keep ldValid up through DONE and into IDLE: nothing may be accepted.
        ldData = 6'h3F; tick();
        tick();
        checks++;
        if ({ldReady, cpuRun} !== 2'b01) begin errors++; $display("FAIL full_idle: ldReady/cpuRun=%b need 01", {ldReady, cpuRun}); end
        ldValid = 1'b0;
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_pulses: got %0d need 1", done_cnt - d0); end
        cpu_read(6'd0, 6'h2A, "full_addr0_no_wrap_write");
        cpu_read(6'd1, 6'h2B, "full_addr1");
        cpu_read(6'd62, 6'h14, "full_addr62");
    endtask

    task automatic test_reset_mid_load();
        int d0;
        d0 = done_cnt;
        cpu_write(6'h3F, 6'h19);
        ldStart = 1'b1; tick();
        ldStart = 1'b0;
        ldValid = 1'b1; ldData = 6'h11; tick();
        ldData = 6'h12; tick();
        // Reset overrides the third word.
        rst = 1'b0; ldData = 6'h13; tick();
        ldValid = 1'b0;
        checks++;
        if ({cpuRun, ldReady, ldDone} !== 3'b100) begin
            errors++; $display("FAIL midrst_ctrl: cpuRun/ldReady/ldDone=%b need 100", {cpuRun, ldReady, ldDone});
        end
        checks++;
        if (ioOut !== 6'h00) begin errors++; $display("FAIL midrst_ioOut: got %h need 00", ioOut); end
        rst = 1'b1; tick();
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: pulses %0d need 0", done_cnt - d0); end
        cpu_read(6'd0, 6'h11, "midrst_addr0_kept");
        cpu_read(6'd1, 6'h12, "midrst_addr1_kept");
        cpu_read(6'd2, 6'h28, "midrst_addr2_untouched");
        // Reload restarts at address 0.
        ldStart = 1'b1; tick();
        ldStart = 1'b0;
        ldValid = 1'b1; ldData = 6'h21; ldLast = 1'b1; tick();
        ldValid = 1'b0; ldLast = 1'b0;
        tick();
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL reload_done_pulses: got %0d need 1", done_cnt - d0); end
        cpu_read(6'd0, 6'h21, "reload_addr0");
        cpu_read(6'd1, 6'h12, "reload_addr1");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_during_write();
        test_io();
        test_load();
        test_full_load();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the 6-bit microcoded CPU. It serves the CPU's memAddr/writeData/writeEn requests and returns readData with one registered cycle of latency; the CPU's half-rate clock absorbs that latency.
- Also provides a memory-mapped I/O register, plus a handshaked program loader that fills the store while the CPU is held off.
- Sits between the CPU and the board top level, on the same clock.

Parameters:
- Wwid, 6, data word width (bits).
- aW, 6, address width; the store holds 2**aW words.
- IOADDR, 6'h3F, address decoded as the I/O register instead of the store.

Ports:
- clk  input  1  board clock; every register in the block uses it.
- rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- memAddr  input  aW  CPU address.
- writeData  input  Wwid  CPU write data.
- writeEn  input  1  CPU write strobe, qualified every clk edge.
- readData  output  Wwid  registered read data returned to the CPU.
- ioIn  input  Wwid  external value returned on reads of IOADDR.
- ioOut  output  Wwid  I/O register, written by the CPU at IOADDR.
- ldStart  input  1  pulse that begins a program load.
- ldValid  input  1  loader data valid.
- ldData  input  Wwid  loader data word.
- ldLast  input  1  marks the final loader word; qualified with ldValid.
- ldReady  output  1  loader may transfer.
- ldDone  output  1  one-cycle pulse when a load completes.
- cpuRun  output  1  high while the CPU may run; the top level gates the CPU reset/clock with it.

Behaviour:
- Store: 2**aW x Wwid array. Its contents are NOT cleared by reset.
- Reset (rst=0 at clk edge):
  - readData=0, ioOut=0, ldReady=0, ldDone=0, cpuRun=1.
  - FSM=IDLE, ldPtr=0.
  - Reset overrides all other activity in that cycle.
- Read path:
  - Every edge, readData <= (memAddr==IOADDR) ? ioIn : store[memAddr].
  - Latency is exactly 1 clk.
  - Reads proceed in every FSM state.
- Read-during-write, same address in the same edge: readData returns the OLD word (read-first). For IOADDR it returns ioIn; ioOut is not fed back.
- CPU write:
  - Accepted only in IDLE with writeEn=1.
  - memAddr!=IOADDR: store[memAddr] <= writeData.
  - memAddr==IOADDR: ioOut <= writeData, and the store is untouched.
  - In LOAD or DONE, CPU writes are ignored entirely (neither the store nor ioOut changes).
- Loader FSM (IDLE, LOAD, DONE):
  - IDLE:
    - cpuRun=1, ldReady=0.
    - ldStart=1 -> LOAD, ldPtr<=0.
    - A CPU write in the same cycle as ldStart is still accepted.
  - LOAD:
    - cpuRun=0, ldReady=1.
    - On ldValid&&ldReady: store[ldPtr] <= ldData (IOADDR included; the CPU never sees that location) and ldPtr <= ldPtr+1, wrapping at aW bits.
    - Go to DONE if ldLast=1, or if ldPtr==2**aW-1 (store full).
    - ldStart is ignored.
    - ldValid=0 stalls indefinitely with no timeout.
  - DONE:
    - Lasts one cycle, then -> IDLE.
    - ldDone=1, cpuRun=0, ldReady=0.
    - ldValid is ignored.
- ldDone is high only in DONE; it never asserts for a load aborted by reset.
- Reset mid-load: the FSM returns to IDLE with cpuRun=1. Words already written stay in the store; no ldDone pulse occurs.
- All outputs are registered or decoded from FSM state only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then write store[5]=6'h2A (writeEn=1, memAddr=5); next cycle read memAddr=5 -> readData=6'h2A exactly one clk after the address is applied; readData=0 during reset.
- Same-edge write 6'h11 then 6'h22 to address 9, with memAddr held at 9 -> readData shows the previous word (6'h11) on the edge that writes 6'h22, and 6'h22 on the following edge.
- Write IOADDR=6'h3F with 6'h15 -> ioOut=6'h15 and store[63] unchanged; with ioIn=6'h07, a read of 6'h3F returns 6'h07.
- ldStart, then 3 words 6'h01, 6'h02, 6'h03 with ldLast on the third, with a ldValid gap between words 1 and 2:
  - cpuRun=0 from the cycle after ldStart until the FSM returns to IDLE.
  - ldDone pulses once.
  - Reads of addresses 0..2 return 1, 2, 3.
  - A CPU write issued during LOAD is absent from the store.
- Load 64 words without ldLast -> DONE after the word at address 63; ldPtr wraps to 0 and the next ldValid is not accepted.
- Assert rst=0 after 2 loader words -> IDLE, cpuRun=1, no ldDone; a subsequent ldStart reloads from address 0.
